// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: 5-stage pipeline sequencing (load-use stall, branch flush, halt drain, counters)
module pipe_hazard_ctrl #(
    parameter int          OP_W      = 6,
    parameter int          REG_W     = 5,
    parameter logic [OP_W-1:0] HALT_OP = '1,
    parameter int          DRAIN_CYC = 3,
    parameter int          CNT_W     = 32
) (
    input  logic             sysclk,
    input  logic             rstd,
    input  logic             id_valid,
    input  logic [OP_W-1:0]  id_op,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_branch_taken,
    input  logic             wb_valid,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             halted,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt
);
    localparam int DW = DRAIN_CYC > 1 ? $clog2(DRAIN_CYC) : 1;
    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALT = 2'd2} state_t;
    state_t         st;
    logic [DW-1:0]  dcnt;
    logic           hazard, halt_id, run, drn;
    assign hazard  = id_valid & ex_valid & ex_is_load & (ex_rd != '0) &
                     ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));
    assign halt_id = id_valid & (id_op == HALT_OP);
    assign run     = st == RUN;
    assign drn     = st == DRAIN;
    assign state   = st;
    always_comb begin
        pc_en       = !rstd & run & (ex_branch_taken | (!halt_id & !hazard));
        ifid_en     = !rstd & (drn | (run & (ex_branch_taken | halt_id | !hazard)));
        ifid_flush  = rstd | drn | (run & (ex_branch_taken | halt_id));
        idex_bubble = rstd | !run | ex_branch_taken | (!halt_id & hazard);
        halted      = !rstd & (st == HALT);
    end
    always_ff @(posedge sysclk) begin
        if (rstd) begin
            st         <= RUN;
            dcnt       <= '0;
            cycle_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            cycle_cnt  <= (st != HALT && cycle_cnt != '1) ? cycle_cnt + CNT_W'(1) : cycle_cnt;
            retire_cnt <= (wb_valid && retire_cnt != '1) ? retire_cnt + CNT_W'(1) : retire_cnt;
            if (run && !ex_branch_taken && halt_id) begin
                st   <= DRAIN;
                dcnt <= DW'(DRAIN_CYC - 1);
            end else if (drn) begin
                st   <= (dcnt == '0) ? HALT : DRAIN;
                dcnt <= (dcnt == '0) ? dcnt : dcnt - DW'(1);
            end
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: randomized + directed scoreboard bench against a behavioural model
module tb_pipe_hazard_ctrl;
    logic        sysclk = 0, rstd = 0;
    logic        id_valid = 0, id_uses_rt = 0, ex_valid = 0, ex_is_load = 0;
    logic        ex_branch_taken = 0, wb_valid = 0;
    logic [5:0]  id_op = 0;
    logic [4:0]  id_rs = 0, id_rt = 0, ex_rd = 0;
    logic        pc_en, ifid_en, ifid_flush, idex_bubble, halted;
    logic        pc_en4, ifid_en4, ifid_flush4, idex_bubble4, halted4;
    logic [1:0]  state, state4;
    logic [31:0] cycle_cnt, retire_cnt;
    logic [3:0]  cycle_cnt4, retire_cnt4;

    always #5 sysclk = ~sysclk;

    pipe_hazard_ctrl dut (
        .sysclk(sysclk), .rstd(rstd), .id_valid(id_valid), .id_op(id_op), .id_rs(id_rs),
        .id_rt(id_rt), .id_uses_rt(id_uses_rt), .ex_valid(ex_valid), .ex_is_load(ex_is_load),
        .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .wb_valid(wb_valid),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .halted(halted), .state(state), .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt));

    pipe_hazard_ctrl #(.CNT_W(4)) dut4 (
        .sysclk(sysclk), .rstd(rstd), .id_valid(id_valid), .id_op(id_op), .id_rs(id_rs),
        .id_rt(id_rt), .id_uses_rt(id_uses_rt), .ex_valid(ex_valid), .ex_is_load(ex_is_load),
        .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .wb_valid(wb_valid),
        .pc_en(pc_en4), .ifid_en(ifid_en4), .ifid_flush(ifid_flush4), .idex_bubble(idex_bubble4),
        .halted(halted4), .state(state4), .cycle_cnt(cycle_cnt4), .retire_cnt(retire_cnt4));

    typedef struct {
        string       tag;
        bit          regs;
        bit [3:0]    ctl;
        bit          halted;
        bit [1:0]    state;
        bit [31:0]   cyc, ret;
        bit [3:0]    cyc4, ret4;
    } exp_t;
    exp_t sb[$];

    int num_cmp = 0, num_bad = 0;

    // Reference model: mode 0=running 1=draining 2=stopped, drain_left = drain cycles still to go
    int      m_mode = 0, drain_left = 0;
    bit      m_known = 0;
    longint  m_cyc = 0, m_ret = 0, m_cyc4 = 0, m_ret4 = 0;

    function automatic longint sat_inc(longint v, longint mx);
        return v < mx ? v + 1 : v;
    endfunction

    task automatic chk(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
        num_cmp++;
        if (act !== exp) begin
            num_bad++;
            $display("FAIL %s.%s at %0t: got %0h expected %0h", tag, what, $time, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit iv, input bit [5:0] op, input bit [4:0] rs,
                        input bit [4:0] rt, input bit urt, input bit ev, input bit ld,
                        input bit [4:0] rd, input bit bt, input bit wb, input string tag);
        exp_t e;
        bit hz, hid;
        rstd = r; id_valid = iv; id_op = op; id_rs = rs; id_rt = rt; id_uses_rt = urt;
        ex_valid = ev; ex_is_load = ld; ex_rd = rd; ex_branch_taken = bt; wb_valid = wb;
        hz  = iv && ev && ld && rd != 0 && (rd == rs || (urt && rd == rt));
        hid = iv && op == 6'h3F;
        e.tag = tag; e.regs = m_known; e.state = 2'(m_mode);
        e.halted = !r && m_mode == 2;
        e.cyc = 32'(m_cyc); e.ret = 32'(m_ret); e.cyc4 = 4'(m_cyc4); e.ret4 = 4'(m_ret4);
        if (r)                e.ctl = 4'b0011;
        else if (m_mode == 2) e.ctl = 4'b0001;
        else if (m_mode == 1) e.ctl = 4'b0111;
        else if (bt)          e.ctl = 4'b1111;
        else if (hid)         e.ctl = 4'b0110;
        else if (hz)          e.ctl = 4'b0001;
        else                  e.ctl = 4'b1100;
        sb.push_back(e);
        @(posedge sysclk); #1;
        if (r) begin
            m_mode = 0; drain_left = 0; m_known = 1;
            m_cyc = 0; m_ret = 0; m_cyc4 = 0; m_ret4 = 0;
        end else begin
            if (m_mode != 2) begin
                m_cyc  = sat_inc(m_cyc, 64'hFFFF_FFFF);
                m_cyc4 = sat_inc(m_cyc4, 15);
            end
            if (wb) begin
                m_ret  = sat_inc(m_ret, 64'hFFFF_FFFF);
                m_ret4 = sat_inc(m_ret4, 15);
            end
            if (m_mode == 0 && !bt && hid) begin
                m_mode = 1; drain_left = 3;
            end else if (m_mode == 1) begin
                drain_left--;
                if (drain_left == 0) m_mode = 2;
            end
        end
    endtask

    task automatic idle(input int n, input bit wb, input string tag);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, wb, tag);
    endtask

    always @(negedge sysclk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.tag, "pc_en", 32'(pc_en), 32'(e.ctl[3]));
            chk(e.tag, "ifid_en", 32'(ifid_en), 32'(e.ctl[2]));
            chk(e.tag, "ifid_flush", 32'(ifid_flush), 32'(e.ctl[1]));
            chk(e.tag, "idex_bubble", 32'(idex_bubble), 32'(e.ctl[0]));
            chk(e.tag, "halted", 32'(halted), 32'(e.halted));
            if (e.regs) begin
                chk(e.tag, "state", 32'(state), 32'(e.state));
                chk(e.tag, "cycle_cnt", cycle_cnt, e.cyc);
                chk(e.tag, "retire_cnt", retire_cnt, e.ret);
                chk(e.tag, "cycle_cnt4", 32'(cycle_cnt4), 32'(e.cyc4));
                chk(e.tag, "retire_cnt4", 32'(retire_cnt4), 32'(e.ret4));
            end
        end
    end

    initial begin
        @(posedge sysclk); #1;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
        idle(2, 0, "run");
        step(0, 1, 0, 5, 0, 0, 1, 1, 5, 0, 0, "loaduse_rs");
        step(0, 1, 0, 5, 0, 0, 0, 0, 5, 0, 0, "loaduse_after");
        step(0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, "loaduse_r0");
        step(0, 1, 0, 1, 5, 0, 1, 1, 5, 0, 0, "rt_unused");
        step(0, 1, 0, 1, 5, 1, 1, 1, 5, 0, 0, "loaduse_rt");
        step(0, 1, 6'h3F, 5, 0, 0, 1, 1, 5, 1, 0, "branch_over");
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "after_branch");
        idle(10, 1, "retire");
        idle(20, 0, "sat4");
        step(0, 1, 6'h3F, 0, 0, 0, 0, 0, 0, 0, 0, "halt_id");
        step(0, 1, 0, 2, 0, 0, 1, 1, 2, 1, 1, "drain");
        idle(2, 0, "drain");
        idle(4, 1, "halted");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset_halt");
        step(0, 1, 6'h3F, 0, 0, 0, 0, 0, 0, 0, 0, "halt_id2");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "drain2");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset_drain");
        idle(2, 0, "after_reset");
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 79) == 0, 1'($urandom), ($urandom_range(0, 29) == 0) ? 6'h3F : 6'($urandom),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                 1'($urandom), 5'($urandom_range(0, 3)), $urandom_range(0, 7) == 0, 1'($urandom), "random");
        idle(2, 0, "tail");
        @(negedge sysclk); #1;
        chk("scoreboard", "pending", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_cmp, num_bad);
        $finish;
    end
endmodule
